// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1R1W SRAM model.
package sram_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    function automatic int byteLanes(input int width);
        return width / 8;
    endfunction

    function automatic bit readLatLegal(input int lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/sram_1r1w_pipe_if.sv
// Request/response bundle of the SRAM; the tristate read data pad stays a plain port.
interface sram_1r1w_pipe_if
    import sram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 9
);
    logic                        CSB1;
    logic                        OEB1;
    logic [AW-1:0]               A1;
    logic                        VLD1;
    logic                        CSB2;
    logic                        WEB2;
    logic [byteLanes(WIDTH)-1:0] BMB2;
    logic [AW-1:0]               A2;
    logic [WIDTH-1:0]            I2;
    logic                        BUSY;

    modport master (
        output CSB1, OEB1, A1, CSB2, WEB2, BMB2, A2, I2,
        input  VLD1, BUSY
    );

    modport slave (
        input  CSB1, OEB1, A1, CSB2, WEB2, BMB2, A2, I2,
        output VLD1, BUSY
    );
endinterface

// File: rtl/sram_byte_merge.sv
// Replaces the bytes of an old word whose active-low mask bit is 0 with new data.
module sram_byte_merge
    import sram_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]            i_old,
    input  logic [WIDTH-1:0]            i_new,
    input  logic [byteLanes(WIDTH)-1:0] i_maskB,
    output logic [WIDTH-1:0]            o_word
);
    always_comb begin
        o_word = i_old;
        for (int i = 0; i < byteLanes(WIDTH); i++) begin
            if (!i_maskB[i]) begin
                o_word[8*i +: 8] = i_new[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/sram_1r1w_pipe.sv
// Single-clock 1R1W SRAM model: byte-masked writes, 1/2-cycle read latency with
// valid strobe, selectable same-address collision policy, optional clear sweep.
module sram_1r1w_pipe
    import sram_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 512,
    parameter int AW             = $clog2(DEPTH),
    parameter int READ_LAT       = 1,
    parameter int BYPASS         = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             CE,
    input  logic             RSTB,
    sram_1r1w_pipe_if.slave  bus,
    output tri   [WIDTH-1:0] O1
);
    localparam bit TWO_STAGE = readLatLegal(READ_LAT) && (READ_LAT == READ_LAT_MAX);

    logic [WIDTH-1:0] r_mem [DEPTH];
    state_t           r_state;
    logic [AW-1:0]    r_clrCnt;
    logic [WIDTH-1:0] r_stgData;
    logic             r_stgVld;
    logic [WIDTH-1:0] r_outData;
    logic             r_vld;

    logic             w_ready;
    logic             w_clearing;
    logic             w_rdAcc;
    logic             w_wrAcc;
    logic             w_rdInRange;
    logic             w_wrInRange;
    logic             w_collide;
    logic [WIDTH-1:0] w_oldRd;
    logic [WIDTH-1:0] w_oldWr;
    logic [WIDTH-1:0] w_wrWord;
    logic [WIDTH-1:0] w_rdData;

    assign w_ready     = (r_state == ST_READY);
    assign w_clearing  = (r_state == ST_CLEAR) && RSTB;
    assign w_rdAcc     = w_ready && !bus.CSB1;
    assign w_wrAcc     = w_ready && !bus.CSB2 && !bus.WEB2;
    assign w_rdInRange = int'(bus.A1) < DEPTH;
    assign w_wrInRange = int'(bus.A2) < DEPTH;
    assign w_oldRd     = w_rdInRange ? r_mem[bus.A1] : '0;
    assign w_oldWr     = w_wrInRange ? r_mem[bus.A2] : '0;

    // One merge feeds both the array write and the collision bypass: on a
    // same-address collision the write-side old word is the read-side old word.
    sram_byte_merge #(.WIDTH(WIDTH)) u_merge (
        .i_old   (w_oldWr),
        .i_new   (bus.I2),
        .i_maskB (bus.BMB2),
        .o_word  (w_wrWord)
    );

    assign w_collide = (BYPASS != 0) && w_rdAcc && w_wrAcc && w_wrInRange && (bus.A1 == bus.A2);
    assign w_rdData  = w_collide ? w_wrWord : w_oldRd;

    // The array has no reset; the clear sweep is held off while RSTB is low.
    always_ff @(posedge CE) begin
        if (w_clearing) begin
            r_mem[r_clrCnt] <= '0;
        end else if (w_wrAcc && w_wrInRange) begin
            r_mem[bus.A2] <= w_wrWord;
        end
    end

    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            r_state  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_clrCnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (int'(r_clrCnt) == DEPTH - 1) begin
                        r_state <= ST_READY;
                    end else begin
                        r_clrCnt <= r_clrCnt + 1'b1;
                    end
                end
                default: r_state <= ST_READY;
            endcase
        end
    end

    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            r_stgData <= '0;
            r_stgVld  <= 1'b0;
            r_outData <= '0;
            r_vld     <= 1'b0;
        end else if (TWO_STAGE) begin
            r_stgVld <= w_rdAcc;
            if (w_rdAcc) begin
                r_stgData <= w_rdData;
            end
            r_vld <= r_stgVld;
            if (r_stgVld) begin
                r_outData <= r_stgData;
            end
        end else begin
            r_vld <= w_rdAcc;
            if (w_rdAcc) begin
                r_outData <= w_rdData;
            end
        end
    end

    assign bus.VLD1 = r_vld;
    assign bus.BUSY = (r_state == ST_CLEAR);
    assign O1       = bus.OEB1 ? {WIDTH{1'bz}} : r_outData;
endmodule

// File: tb/tb_sram_1r1w_pipe.sv
// Directed bench: dutA = 16 words, latency 1, bypass; dutB = 12 words, latency 2, no bypass.
module tb_sram_1r1w_pipe;
    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;
    int   busyA;
    int   busyB;
    logic sawVld;

    always #5 clk = ~clk;

    sram_1r1w_pipe_if #(.WIDTH(32), .AW(4)) ifA ();
    sram_1r1w_pipe_if #(.WIDTH(32), .AW(4)) ifB ();
    wire [31:0] o1A;
    wire [31:0] o1B;

    sram_1r1w_pipe #(.WIDTH(32), .DEPTH(16), .AW(4), .READ_LAT(1), .BYPASS(1), .CLEAR_ON_RESET(1)) dutA (
        .CE(clk), .RSTB(rstN), .bus(ifA), .O1(o1A)
    );

    sram_1r1w_pipe #(.WIDTH(32), .DEPTH(12), .AW(4), .READ_LAT(2), .BYPASS(0), .CLEAR_ON_RESET(1)) dutB (
        .CE(clk), .RSTB(rstN), .bus(ifB), .O1(o1B)
    );

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idleA();
        ifA.CSB1 = 1'b1; ifA.OEB1 = 1'b0; ifA.A1 = '0;
        ifA.CSB2 = 1'b1; ifA.WEB2 = 1'b1; ifA.BMB2 = '1; ifA.A2 = '0; ifA.I2 = '0;
    endtask

    task automatic idleB();
        ifB.CSB1 = 1'b1; ifB.OEB1 = 1'b0; ifB.A1 = '0;
        ifB.CSB2 = 1'b1; ifB.WEB2 = 1'b1; ifB.BMB2 = '1; ifB.A2 = '0; ifB.I2 = '0;
    endtask

    task automatic writeA(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] mask);
        ifA.CSB2 = 1'b0; ifA.WEB2 = 1'b0; ifA.A2 = addr; ifA.I2 = data; ifA.BMB2 = mask;
    endtask

    task automatic writeB(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] mask);
        ifB.CSB2 = 1'b0; ifB.WEB2 = 1'b0; ifB.A2 = addr; ifB.I2 = data; ifB.BMB2 = mask;
    endtask

    task automatic readA(input logic [3:0] addr);
        ifA.CSB1 = 1'b0; ifA.A1 = addr;
    endtask

    task automatic readB(input logic [3:0] addr);
        ifB.CSB1 = 1'b0; ifB.A1 = addr;
    endtask

    initial begin
        idleA();
        idleB();
        applyStimulus(2);
        checkOutput("rst_busyA", 32'(ifA.BUSY), 32'd1);
        checkOutput("rst_busyB", 32'(ifB.BUSY), 32'd1);
        checkOutput("rst_vldA",  32'(ifA.VLD1), 32'd0);
        checkOutput("rst_o1A",   o1A,           32'd0);
        checkOutput("rst_o1B",   o1B,           32'd0);

        // Release, then pull reset again once seven clear writes have happened.
        rstN   = 1'b1;
        sawVld = 1'b0;
        for (int i = 0; i < 7; i++) begin
            writeA(4'd0, 32'h55, 4'b0000);
            readA(4'd0);
            applyStimulus(1);
            sawVld = sawVld | ifA.VLD1;
        end
        checkOutput("busy_at_cnt7", 32'(ifA.BUSY), 32'd1);
        rstN = 1'b0;
        #2;
        checkOutput("midclr_rst_busy", 32'(ifA.BUSY), 32'd1);
        rstN = 1'b1;

        busyA = 0;
        busyB = 0;
        for (int i = 0; i < 40; i++) begin
            if (!ifA.BUSY && !ifB.BUSY) break;
            if (ifA.BUSY) busyA++;
            if (ifB.BUSY) busyB++;
            if (ifA.BUSY) begin
                writeA(4'd0, 32'h55, 4'b0000);
                readA(4'd0);
            end else begin
                idleA();
            end
            applyStimulus(1);
            sawVld = sawVld | ifA.VLD1;
        end
        idleA();
        checkOutput("busy_len_A", 32'(busyA), 32'd16);
        checkOutput("busy_len_B", 32'(busyB), 32'd12);
        checkOutput("no_vld_in_clear", 32'(sawVld), 32'd0);

        for (int a = 0; a < 16; a++) begin
            readA(4'(a));
            applyStimulus(1);
            checkOutput($sformatf("clr_rd%0d_data", a), o1A, 32'd0);
            checkOutput($sformatf("clr_rd%0d_vld", a), 32'(ifA.VLD1), 32'd1);
        end
        idleA();

        // Byte-masked overwrite at address 5.
        writeA(4'd5, 32'hDEADBEEF, 4'b0000);
        applyStimulus(1);
        writeA(4'd5, 32'h11223344, 4'b1010);
        applyStimulus(1);
        idleA();
        readA(4'd5);
        applyStimulus(1);
        checkOutput("mask_rd_data", o1A, 32'hDE22BE44);
        checkOutput("mask_rd_vld", 32'(ifA.VLD1), 32'd1);
        idleA();
        applyStimulus(1);
        checkOutput("gap_vld", 32'(ifA.VLD1), 32'd0);
        checkOutput("gap_hold", o1A, 32'hDE22BE44);

        // Output enable gates the pad only.
        readA(4'd5);
        ifA.OEB1 = 1'b1;
        applyStimulus(1);
        checkOutput("oeb_vld", 32'(ifA.VLD1), 32'd1);
        checkOutput("oeb_not_driven", 32'(o1A === 32'hDE22BE44), 32'd0);
        ifA.OEB1 = 1'b0;
        #1;
        checkOutput("oeb_release", o1A, 32'hDE22BE44);
        idleA();

        // Collisions on the bypassing instance.
        writeA(4'd9, 32'hFFFFFFFF, 4'b0000);
        readA(4'd9);
        applyStimulus(1);
        checkOutput("bypass_full", o1A, 32'hFFFFFFFF);
        idleA();
        readA(4'd9);
        applyStimulus(1);
        checkOutput("bypass_full_after", o1A, 32'hFFFFFFFF);
        writeA(4'd5, 32'h000000AA, 4'b1110);
        readA(4'd5);
        applyStimulus(1);
        checkOutput("bypass_partial", o1A, 32'hDE22BEAA);
        idleA();
        readA(4'd5);
        applyStimulus(1);
        checkOutput("bypass_partial_after", o1A, 32'hDE22BEAA);
        idleA();

        // Two-cycle pipeline on dutB.
        writeB(4'd1, 32'hA, 4'b0000);
        applyStimulus(1);
        writeB(4'd2, 32'hB, 4'b0000);
        applyStimulus(1);
        writeB(4'd3, 32'hC, 4'b0000);
        applyStimulus(1);
        idleB();
        readB(4'd1);
        applyStimulus(1);
        checkOutput("lat2_e1_vld", 32'(ifB.VLD1), 32'd0);
        readB(4'd2);
        applyStimulus(1);
        checkOutput("lat2_e2_data", o1B, 32'hA);
        checkOutput("lat2_e2_vld", 32'(ifB.VLD1), 32'd1);
        readB(4'd3);
        applyStimulus(1);
        checkOutput("lat2_e3_data", o1B, 32'hB);
        checkOutput("lat2_e3_vld", 32'(ifB.VLD1), 32'd1);
        ifB.CSB1 = 1'b1;
        applyStimulus(1);
        checkOutput("lat2_e4_data", o1B, 32'hC);
        checkOutput("lat2_e4_vld", 32'(ifB.VLD1), 32'd1);
        readB(4'd1);
        applyStimulus(1);
        checkOutput("lat2_e5_vld_gap", 32'(ifB.VLD1), 32'd0);
        checkOutput("lat2_e5_hold", o1B, 32'hC);
        idleB();
        applyStimulus(1);
        checkOutput("lat2_e6_data", o1B, 32'hA);
        checkOutput("lat2_e6_vld", 32'(ifB.VLD1), 32'd1);
        applyStimulus(1);
        checkOutput("lat2_e7_vld", 32'(ifB.VLD1), 32'd0);

        // Collision without bypass returns the old word.
        writeB(4'd9, 32'hFFFFFFFF, 4'b0000);
        readB(4'd9);
        applyStimulus(1);
        idleB();
        readB(4'd9);
        applyStimulus(1);
        checkOutput("nobypass_old", o1B, 32'h0);
        checkOutput("nobypass_vld", 32'(ifB.VLD1), 32'd1);
        idleB();
        applyStimulus(1);
        checkOutput("nobypass_after", o1B, 32'hFFFFFFFF);

        // Out-of-range address on the 12-word instance.
        writeB(4'd13, 32'h12345678, 4'b0000);
        applyStimulus(1);
        idleB();
        readB(4'd13);
        applyStimulus(1);
        readB(4'd1);
        applyStimulus(1);
        checkOutput("oor_data", o1B, 32'h0);
        checkOutput("oor_vld", 32'(ifB.VLD1), 32'd1);
        idleB();
        applyStimulus(1);
        checkOutput("oor_neighbour", o1B, 32'hA);

        // Reset while a two-cycle read is in flight.
        readB(4'd2);
        applyStimulus(1);
        idleB();
        rstN = 1'b0;
        #2;
        checkOutput("inflight_rst_vld", 32'(ifB.VLD1), 32'd0);
        checkOutput("inflight_rst_o1", o1B, 32'd0);
        rstN = 1'b1;
        applyStimulus(1);
        checkOutput("inflight_dropped", 32'(ifB.VLD1), 32'd0);
        checkOutput("inflight_busy", 32'(ifB.BUSY), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/sram_1r1w_pipe.md
Name: sram_1r1w_pipe

Overview:
- Parametrised single-clock 1R1W SRAM behavioural macro.
- Extends the fixed 512x32 dual-clock model with the following:
  - configurable width and depth
  - per-byte write mask
  - selectable read latency (1 or 2) with a valid strobe
  - configurable read/write same-address collision policy
  - optional hardware clear sequence after reset
- Instantiated by cache/scratchpad arrays in place of hand-sized macros.

Parameters:
- WIDTH, 32, data bits per word; must be a multiple of 8.
- DEPTH, 512, number of words; need not be a power of 2.
- AW, $clog2(DEPTH), address width.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- BYPASS, 0, collision policy: 1 = read returns the newly written data, 0 = read returns the old data.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting traffic.

Ports:
- CE  input  1  clock; all state updates on posedge.
- RSTB  input  1  asynchronous active-low reset.
- CSB1  input  1  read chip select, active low.
- OEB1  input  1  output enable, active low; O1 = high-Z when 1.
- A1  input  AW  read address.
- O1  output  WIDTH  read data.
- VLD1  output  1  high for one cycle when O1 holds data from a read accepted READ_LAT edges earlier.
- CSB2  input  1  write chip select, active low.
- WEB2  input  1  write enable, active low.
- BMB2  input  WIDTH/8  byte write mask, active low; bit i guards I2[8i+7:8i].
- A2  input  AW  write address.
- I2  input  WIDTH  write data.
- BUSY  output  1  clear sequence in progress; all requests ignored while high.

Behaviour:
- Reset (RSTB low, asynchronous):
  - Output data register = 0; VLD1 = 0; pipeline stage valid bits = 0; clear counter = 0.
  - BUSY = CLEAR_ON_RESET.
  - Array contents are unchanged by reset itself.
- FSM states: CLEAR, READY. Reset enters CLEAR if CLEAR_ON_RESET = 1, else READY.
- CLEAR:
  - Writes 0 to address = counter on each edge, then increments the counter.
  - After the DEPTH-1 write, moves to READY; BUSY deasserts on that same edge, so BUSY is high for exactly DEPTH cycles.
  - Reads and writes presented in CLEAR are dropped silently; VLD1 stays 0.
  - Reset mid-clear restarts the sequence at address 0.
- Write (READY): on posedge with CSB2 = 0 and WEB2 = 0, for each i with BMB2[i] = 0, mem[A2] byte i <= I2 byte i. Unmasked bytes keep their old value.
- Read (READY): accepted on posedge with CSB1 = 0.
  - READ_LAT = 1: O1 data register and VLD1 update on that edge.
  - READ_LAT = 2: the array read lands in stage 1 on that edge and moves to the O1 register on the next edge; VLD1 is high one cycle later.
  - Back-to-back reads are accepted every cycle; throughput is 1 per cycle.
- When CSB1 = 1: the O1 data register holds its last value and VLD1 = 0 for that slot.
- Collision (same A1 = A2, both accepted on the same edge):
  - BYPASS = 1: read data = old word with masked-in bytes replaced by I2.
  - BYPASS = 0: read data = old word.
  - The array is updated in both cases.
- Address >= DEPTH: the write is dropped; the read returns 0 with VLD1 still asserted.
- OEB1 acts combinationally on O1 only; it does not affect VLD1 or pipeline state.
- Reset during an in-flight READ_LAT = 2 read: the read is discarded and no VLD1 follows.

Decomposition:
- Shared package sram_pkg holds:
  - the FSM state enum {CLEAR, READY}
  - a byte-lane count helper function
  - the READ_LAT legality check constant
- One sub-module, sram_byte_merge: combinational old/new/mask merge. It is used by both the write path and the bypass path.

Test Plan:
- CLEAR_ON_RESET = 1, DEPTH = 16: release RSTB -> BUSY high for exactly 16 cycles; then read all 16 addresses -> O1 = 0 with VLD1 each cycle. Assert RSTB at counter 7 -> counter restarts at 0 and BUSY lasts a further 16 cycles.
- Write 0xDEADBEEF to address 5 with BMB2 = 4'b0000, then write 0x11223344 to address 5 with BMB2 = 4'b1010 -> read of address 5 returns 0xDE22BE44.
- READ_LAT = 2: reads of addresses 1, 2, 3 on consecutive cycles (holding 0xA, 0xB, 0xC) -> O1 = 0xA, 0xB, 0xC on edges 2, 3, 4 with VLD1 high on each; a CSB1 gap produces a VLD1 gap.
- Collision at address 9 (old value 0x0, write 0xFFFFFFFF, BMB2 = 0):
  - BYPASS = 1 -> read returns 0xFFFFFFFF.
  - BYPASS = 0 -> read returns 0x0.
  - In both cases, a following read returns 0xFFFFFFFF.
- DEPTH = 12: write to address 13 -> no array change; read of address 13 -> O1 = 0, VLD1 = 1. OEB1 = 1 -> O1 = Z while VLD1 still pulses.
- Traffic during BUSY: write 0x55 to address 0 in CLEAR -> after clear completes, address 0 reads 0.
